// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state type and synchronizer depth for the debouncer
package debounce_pkg;
  localparam int SYNC_STAGES = 2;
  typedef enum logic [1:0] {S_STABLE_LOW, S_WAIT_HIGH, S_STABLE_HIGH, S_WAIT_LOW} debounce_state_t;
endpackage

// File: rtl/debouncer_synchronizer.sv
// synchronizer: STAGES-deep flop chain, sync reset to RESET_VALUE (clk, rst, d -> q)
module synchronizer #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk) ff <= rst ? {STAGES{RESET_VALUE}} : STAGES'({ff, d});
  assign q = ff[STAGES-1];
endmodule

// File: rtl/debouncer.sv
// debouncer: clk, rst, raw in -> registered debounced out and busy; DEBOUNCER_SYNC_EN adds a 2-flop input synchronizer
module debouncer
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = 16,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic busy
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  if (STABLE_CYCLES < 2) begin : g_bad_cfg
    $error("debouncer: STABLE_CYCLES must be >= 2");
  end
  logic s;
`ifdef DEBOUNCER_SYNC_EN
  synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(RESET_LEVEL)) u_sync (
    .clk(clk),
    .rst(rst),
    .d(in),
    .q(s)
  );
`else
  assign s = in;
`endif
  debounce_state_t state, state_n;
  logic [CW-1:0] count, count_n;
  always_ff @(posedge clk) begin
    state <= rst ? (RESET_LEVEL ? S_STABLE_HIGH : S_STABLE_LOW) : state_n;
    count <= rst ? '0 : count_n;
  end
  always_comb begin
    state_n = state;
    count_n = '0;
    case (state)
      S_STABLE_LOW: if (s) begin
        state_n = S_WAIT_HIGH;
        count_n = CW'(1);
      end
      S_WAIT_HIGH:
        if (!s) state_n = S_STABLE_LOW;
        else if (count == LAST) state_n = S_STABLE_HIGH;
        else count_n = count + 1'b1;
      S_STABLE_HIGH: if (!s) begin
        state_n = S_WAIT_LOW;
        count_n = CW'(1);
      end
      S_WAIT_LOW:
        if (s) state_n = S_STABLE_HIGH;
        else if (count == LAST) state_n = S_STABLE_LOW;
        else count_n = count + 1'b1;
    endcase
  end
  assign out  = state == S_STABLE_HIGH || state == S_WAIT_LOW;
  assign busy = state == S_WAIT_HIGH || state == S_WAIT_LOW;
endmodule

// File: tb/tb_debouncer.sv
// tb_debouncer: randomized and directed checks of debouncer against a sample-window reference model
module tb_debouncer;
  localparam int N = 4;
`ifdef DEBOUNCER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in = 1'b0;
  logic out0, busy0, out1, busy1;
  logic [1:0] o, b;
  int vectors = 0;
  int miscompares = 0;
  assign o = {out1, out0};
  assign b = {busy1, busy0};
  always #5 clk = ~clk;
  debouncer #(.STABLE_CYCLES(N), .RESET_LEVEL(1'b0)) dut0 (.clk(clk), .rst(rst), .in(in), .out(out0), .busy(busy0));
  debouncer #(.STABLE_CYCLES(N), .RESET_LEVEL(1'b1)) dut1 (.clk(clk), .rst(rst), .in(in), .out(out1), .busy(busy1));
  // Model: out flips once the last N sampled values all disagree with it;
  // busy means the newest sample disagrees with out without having flipped.
  bit dl [2][3];
  bit hist [2][N];
  bit m_out [2];
  bit m_busy [2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int j = 0; j < 3; j++) dl[i][j] = (i == 1);
        for (int j = 0; j < N; j++) hist[i][j] = (i == 1);
        m_out[i] = (i == 1);
        m_busy[i] = 1'b0;
      end else begin
        bit s, all_diff;
        dl[i][2] = dl[i][1];
        dl[i][1] = dl[i][0];
        dl[i][0] = in;
        s = dl[i][LAT];
        for (int j = N - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = s;
        all_diff = 1'b1;
        for (int j = 0; j < N; j++) if (hist[i][j] == m_out[i]) all_diff = 1'b0;
        if (all_diff) m_out[i] = ~m_out[i];
        m_busy[i] = s != m_out[i];
      end
    end
  end
  task automatic test_reset;
    rst = 1'b1;
    in = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (out0 !== 1'b0 || busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rl0: out=%b busy=%b, want out=0 busy=0", out0, busy0);
    end
    vectors++;
    if (out1 !== 1'b1 || busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rl1: out=%b busy=%b, want out=1 busy=0", out1, busy1);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_rise;
    in = 1'b1;
    for (int e = 1; e <= LAT + N + 2; e++) begin
      bit eo, eb;
      @(negedge clk);
      eo = e >= LAT + N;
      eb = e >= LAT + 1 && e < LAT + N;
      vectors++;
      if (out0 !== eo || busy0 !== eb) begin
        miscompares++;
        $display("FAIL rise_edge%0d: out=%b busy=%b, want out=%b busy=%b", e, out0, busy0, eo, eb);
      end
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (o[i] !== m_out[i] || b[i] !== m_busy[i]) begin
          miscompares++;
          $display("FAIL rise_model dut%0d: out=%b busy=%b, want out=%b busy=%b", i, o[i], b[i], m_out[i], m_busy[i]);
        end
      end
    end
    in = 1'b0;
    for (int e = 1; e <= LAT + N + 2; e++) begin
      bit eo;
      @(negedge clk);
      eo = e < LAT + N;
      vectors++;
      if (out0 !== eo || out1 !== eo) begin
        miscompares++;
        $display("FAIL fall_edge%0d: out0=%b out1=%b, want %b", e, out0, out1, eo);
      end
    end
  endtask
  task automatic test_glitch;
    for (int len = 1; len < N; len++) begin
      in = 1'b1;
      repeat (len) @(negedge clk);
      in = 1'b0;
      for (int e = 0; e < LAT + N + 2; e++) begin
        @(negedge clk);
        vectors++;
        if (out0 !== 1'b0 || out0 !== m_out[0] || busy0 !== m_busy[0]) begin
          miscompares++;
          $display("FAIL glitch_len%0d: out=%b busy=%b, want out=0 busy=%b", len, out0, busy0, m_busy[0]);
        end
      end
    end
  endtask
  task automatic test_toggle;
    for (int c = 0; c < 20 + LAT + N + 2; c++) begin
      in = c < 20 ? ~in : 1'b0;
      @(negedge clk);
      vectors++;
      if (out0 !== 1'b0 || busy0 !== m_busy[0]) begin
        miscompares++;
        $display("FAIL toggle_c%0d: out=%b busy=%b, want out=0 busy=%b", c, out0, busy0, m_busy[0]);
      end
    end
    vectors++;
    if (busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL toggle_idle: busy=%b, want 0", busy0);
    end
  endtask
  task automatic test_reset_mid;
    in = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    vectors++;
    if (busy0 !== 1'b1 || out0 !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_pre: out=%b busy=%b, want out=0 busy=1", out0, busy0);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy0 !== 1'b0 || out0 !== 1'b0 || out1 !== 1'b1 || busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_rst: out0=%b busy0=%b out1=%b busy1=%b, want 0 0 1 0", out0, busy0, out1, busy1);
    end
    rst = 1'b0;
    for (int e = 1; e <= LAT + N; e++) begin
      @(negedge clk);
      vectors++;
      if (out0 !== (e == LAT + N)) begin
        miscompares++;
        $display("FAIL midrst_edge%0d: out=%b, want %b", e, out0, e == LAT + N);
      end
    end
    in = 1'b0;
    repeat (LAT + N + 2) @(negedge clk);
  endtask
  task automatic test_bouncy;
    int rises = 0, falls = 0;
    logic prev = out0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int t = 0; t < 5; t++) begin
        in = ~in;
        repeat ($urandom_range(1, N - 1)) begin
          @(negedge clk);
          rises += int'(out0 && !prev);
          falls += int'(!out0 && prev);
          prev = out0;
        end
      end
      repeat (LAT + N + 4) begin
        @(negedge clk);
        rises += int'(out0 && !prev);
        falls += int'(!out0 && prev);
        prev = out0;
      end
    end
    vectors++;
    if (rises != 1 || falls != 1) begin
      miscompares++;
      $display("FAIL bouncy_edges: rises=%0d falls=%0d, want 1 and 1", rises, falls);
    end
  endtask
  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) in = ~in;
      rst = $urandom_range(0, 60) == 0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (o[i] !== m_out[i] || b[i] !== m_busy[i]) begin
          miscompares++;
          $display("FAIL random_c%0d dut%0d: out=%b busy=%b, want out=%b busy=%b", c, i, o[i], b[i], m_out[i], m_busy[i]);
        end
      end
    end
    rst = 1'b0;
  endtask
  task automatic test_back_to_back;
    in = 1'b1;
    repeat (LAT + N) @(negedge clk);
    in = 1'b0;
    for (int e = 1; e <= LAT + N; e++) begin
      @(negedge clk);
      vectors++;
      if (out0 !== (e < LAT + N) || busy0 !== m_busy[0]) begin
        miscompares++;
        $display("FAIL b2b_edge%0d: out=%b busy=%b, want out=%b busy=%b", e, out0, busy0, e < LAT + N, m_busy[0]);
      end
    end
  endtask
  initial begin
    test_reset;
    test_rise;
    test_glitch;
    test_toggle;
    test_reset_mid;
    test_bouncy;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
